// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
//==============================================================================
// Package : dmem_arbiter_pkg
// Brief   : Shared ownership states and access encodings for dmem_arbiter.
// Rev     : 1.0  initial release
//==============================================================================
package dmem_arbiter_pkg;

    typedef enum logic [0:0] {
        OWN_P = 1'b0,
        OWN_L = 1'b1
    } arb_state_e;

    localparam logic RW_READ   = 1'b0;
    localparam logic RW_WRITE  = 1'b1;
    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

endpackage
`default_nettype wire

// File: rtl/dmem_arb_counter.sv
`default_nettype none
//==============================================================================
// Module  : dmem_arb_counter
// Brief   : Saturating up-counter with synchronous clear; clear beats increment.
// Rev     : 1.0  initial release
//==============================================================================
module dmem_arb_counter #(
    parameter int WIDTH = 8,
    parameter int MAX   = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_MAX)) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
//==============================================================================
// Module  : dmem_arbiter
// Brief   : Shares the data-memory port between the pipeline MEM stage (P,
//           default owner) and a loader/debug requester (L) with starvation
//           and burst limits.
// Options : DMEM_ARB_STATS_EN adds stall_cycles / ld_grants statistics ports.
// Rev     : 1.0  initial release
//==============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int STARVE_LIMIT = 8,
    parameter int MAX_BURST    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_E,
    input  logic              p_RW,
    input  logic              p_Size,
    input  logic [31:0]       p_AD,
    input  logic [31:0]       p_IN,
    output logic              p_stall,
    output logic [31:0]       p_rdata,
    input  logic              ld_req,
    input  logic              ld_RW,
    input  logic              ld_Size,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic              ld_ack,
    output logic [31:0]       ld_rdata,
    output logic              m_E,
    output logic              m_RW,
    output logic              m_Size,
    output logic [ADDR_W-1:0] m_A,
    output logic [31:0]       m_DI,
    input  logic [31:0]       m_DO
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]       stall_cycles,
    output logic [15:0]       ld_grants
`endif
);

    localparam logic [0:0] S_OWN_P = OWN_P;
    localparam logic [0:0] S_OWN_L = OWN_L;

    localparam int c_WAIT_W  = $clog2(STARVE_LIMIT + 1);
    localparam int c_BURST_W = $clog2(MAX_BURST + 1);

    localparam logic [c_WAIT_W-1:0]  c_WAIT_LAST = c_WAIT_W'(STARVE_LIMIT - 1);
    localparam logic [c_BURST_W-1:0] c_BURST_MAX = c_BURST_W'(MAX_BURST);

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic                 r_ld_ack;
    logic [31:0]          r_ld_rdata;
    logic [c_WAIT_W-1:0]  w_wait_cnt;
    logic [c_BURST_W-1:0] w_burst_cnt;

    logic w_access;
    logic w_grant;
    logic w_release;
    logic w_wait_inc;

    // Only the low ADDR_W address bits reach the memory.
    logic w_unused_p_ad;
    assign w_unused_p_ad = ^p_AD[31:ADDR_W];

    always_comb begin
        w_access   = (r_state == S_OWN_L) && ld_req && !r_ld_ack;
        w_grant    = (r_state == S_OWN_P) && ld_req &&
                     (!p_E || (w_wait_cnt == c_WAIT_LAST));
        w_release  = (r_state == S_OWN_L) &&
                     ((!ld_req && !r_ld_ack) ||
                      (r_ld_ack && p_E && (w_burst_cnt == c_BURST_MAX)));
        w_wait_inc = (r_state == S_OWN_P) && ld_req && p_E;

        w_state_nxt = r_state;
        if (w_grant) begin
            w_state_nxt = S_OWN_L;
        end else if (w_release) begin
            w_state_nxt = S_OWN_P;
        end
    end

    dmem_arb_counter #(
        .WIDTH (c_WAIT_W),
        .MAX   (STARVE_LIMIT)
    ) u_wait_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_clr   (w_grant),
        .i_inc   (w_wait_inc),
        .o_count (w_wait_cnt)
    );

    dmem_arb_counter #(
        .WIDTH (c_BURST_W),
        .MAX   (MAX_BURST)
    ) u_burst_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_clr   (w_grant),
        .i_inc   (w_access),
        .o_count (w_burst_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_OWN_P;
            r_ld_ack   <= 1'b0;
            r_ld_rdata <= 32'h0;
        end else begin
            r_state  <= w_state_nxt;
            r_ld_ack <= w_access;
            if (w_access && (ld_RW == RW_READ)) begin
                r_ld_rdata <= m_DO;
            end
        end
    end

    // In OWN_L the port stays pointed at the loader; m_E only pulses on access cycles.
    always_comb begin
        if (r_state == S_OWN_L) begin
            m_E     = w_access;
            m_RW    = ld_RW;
            m_Size  = ld_Size;
            m_A     = ld_addr;
            m_DI    = ld_wdata;
            p_stall = p_E;
        end else begin
            m_E     = p_E;
            m_RW    = p_RW;
            m_Size  = p_Size;
            m_A     = p_AD[ADDR_W-1:0];
            m_DI    = p_IN;
            p_stall = 1'b0;
        end
        if (reset) begin
            m_E     = 1'b0;
            p_stall = 1'b0;
        end
    end

    assign p_rdata  = m_DO;
    assign ld_ack   = r_ld_ack;
    assign ld_rdata = r_ld_rdata;

`ifdef DMEM_ARB_STATS_EN
    dmem_arb_counter #(
        .WIDTH (16),
        .MAX   (16'hFFFF)
    ) u_stall_stat (
        .clk     (clk),
        .rst     (reset),
        .i_clr   (1'b0),
        .i_inc   (p_stall),
        .o_count (stall_cycles)
    );

    dmem_arb_counter #(
        .WIDTH (16),
        .MAX   (16'hFFFF)
    ) u_grant_stat (
        .clk     (clk),
        .rst     (reset),
        .i_clr   (1'b0),
        .i_inc   (w_grant),
        .o_count (ld_grants)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
//==============================================================================
// Module  : tb_dmem_arbiter
// Brief   : Directed checks of dmem_arbiter with a simple data-memory model.
//           Stats ports are exercised when DMEM_ARB_STATS_EN is defined.
// Rev     : 1.0  initial release
//==============================================================================
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        p_E, p_RW, p_Size;
    logic [31:0] p_AD, p_IN;
    logic        p_stall;
    logic [31:0] p_rdata;
    logic        ld_req, ld_RW, ld_Size;
    logic [7:0]  ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_ack;
    logic [31:0] ld_rdata;
    logic        m_E, m_RW, m_Size;
    logic [7:0]  m_A;
    logic [31:0] m_DI, m_DO;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stall_cycles, ld_grants;
`endif

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(
        .ADDR_W       (8),
        .STARVE_LIMIT (8),
        .MAX_BURST    (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .p_E      (p_E),
        .p_RW     (p_RW),
        .p_Size   (p_Size),
        .p_AD     (p_AD),
        .p_IN     (p_IN),
        .p_stall  (p_stall),
        .p_rdata  (p_rdata),
        .ld_req   (ld_req),
        .ld_RW    (ld_RW),
        .ld_Size  (ld_Size),
        .ld_addr  (ld_addr),
        .ld_wdata (ld_wdata),
        .ld_ack   (ld_ack),
        .ld_rdata (ld_rdata),
        .m_E      (m_E),
        .m_RW     (m_RW),
        .m_Size   (m_Size),
        .m_A      (m_A),
        .m_DI     (m_DI),
        .m_DO     (m_DO)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .ld_grants    (ld_grants)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-per-address memory; byte writes touch the low byte only.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (m_E && m_RW) begin
            mem[m_A] <= m_Size ? m_DI : {mem[m_A][31:8], m_DI[7:0]};
        end
    end
    assign m_DO = m_Size ? mem[m_A] : {24'h0, mem[m_A][7:0]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int obs_stall;
    int acks;
    int p_after;

    initial begin
        reset = 1'b1;  p_E = 1'b1;  p_RW = 1'b0;  p_Size = 1'b1;
        p_AD = 32'h0000_0040;  p_IN = 32'h0;
        ld_req = 1'b0;  ld_RW = 1'b0;  ld_Size = 1'b1;
        ld_addr = 8'h10;  ld_wdata = 32'h0;
        obs_stall = 0;  acks = 0;  p_after = 0;

        // Reset: memory enable forced low even with p_E=1
        #7;
        chk("rst_m_E", 32'(m_E), 32'd0);
        chk("rst_p_stall", 32'(p_stall), 32'd0);
        tick();
        tick();
        reset = 1'b0;  p_E = 1'b0;
        #1;
        chk("post_rst_ld_ack", 32'(ld_ack), 32'd0);
        chk("post_rst_ld_rdata", ld_rdata, 32'h0);
        chk("post_rst_own_p", 32'(m_A), 32'h40);

        // Idle P, loader word write then read of 0x10
        ld_req = 1'b1;  ld_RW = 1'b1;  ld_Size = 1'b1;  ld_wdata = 32'hDEAD_BEEF;
        #1;
        chk("wr_c0_m_E", 32'(m_E), 32'd0);
        chk("wr_c0_m_A", 32'(m_A), 32'h40);
        tick();
        chk("wr_c1_m_E", 32'(m_E), 32'd1);
        chk("wr_c1_m_A", 32'(m_A), 32'h10);
        chk("wr_c1_m_RW", 32'(m_RW), 32'd1);
        chk("wr_c1_m_DI", m_DI, 32'hDEAD_BEEF);
        chk("wr_c1_ld_ack", 32'(ld_ack), 32'd0);
        tick();
        chk("wr_c2_ld_ack", 32'(ld_ack), 32'd1);
        chk("wr_c2_m_E", 32'(m_E), 32'd0);
        ld_RW = 1'b0;
        tick();
        chk("rd_c3_m_E", 32'(m_E), 32'd1);
        chk("rd_c3_m_RW", 32'(m_RW), 32'd0);
        tick();
        chk("rd_c4_ld_ack", 32'(ld_ack), 32'd1);
        chk("rd_c4_ld_rdata", ld_rdata, 32'hDEAD_BEEF);
        ld_req = 1'b0;
        tick();
        chk("rd_c5_ld_ack", 32'(ld_ack), 32'd0);
        tick();
        chk("rd_c6_own_p", 32'(m_A), 32'h40);

        // P byte write, then byte read back through p_rdata
        p_E = 1'b1;  p_RW = 1'b1;  p_Size = 1'b0;
        p_AD = 32'h0000_0123;  p_IN = 32'h0000_00AB;
        #1;
        chk("pb_m_A", 32'(m_A), 32'h23);
        chk("pb_m_Size", 32'(m_Size), 32'd0);
        chk("pb_m_E", 32'(m_E), 32'd1);
        chk("pb_m_DI", m_DI, 32'hAB);
        chk("pb_p_stall", 32'(p_stall), 32'd0);
        tick();
        p_RW = 1'b0;
        #1;
        chk("pb_readback", p_rdata, 32'h0000_00AB);
        tick();

        // Fresh reset so the statistics start from zero
        reset = 1'b1;  p_E = 1'b0;
        tick();
        reset = 1'b0;
`ifdef DMEM_ARB_STATS_EN
        #1;
        chk("stat_rst_stall", 32'(stall_cycles), 32'd0);
        chk("stat_rst_grants", 32'(ld_grants), 32'd0);
`endif

        // Starvation: P busy every cycle, loader read held from cycle 0
        p_E = 1'b1;  p_RW = 1'b0;  p_Size = 1'b1;  p_AD = 32'h0000_0040;
        ld_req = 1'b1;  ld_RW = 1'b0;  ld_Size = 1'b1;  ld_addr = 8'h10;
        begin
            int early_stalls;
            int early_l;
            early_stalls = 0;
            early_l = 0;
            for (int i = 0; i < 8; i++) begin
                #1;
                if (p_stall) early_stalls++;
                if (m_A == 8'h10) early_l++;
                tick();
            end
            chk("stv_no_early_stall", 32'(early_stalls), 32'd0);
            chk("stv_no_early_grant", 32'(early_l), 32'd0);
        end
        #1;
        chk("stv_c8_m_E", 32'(m_E), 32'd1);
        chk("stv_c8_m_A", 32'(m_A), 32'h10);
        chk("stv_c8_p_stall", 32'(p_stall), 32'd1);
        if (p_stall) obs_stall++;
        tick();
        chk("stv_c9_ld_ack", 32'(ld_ack), 32'd1);
        chk("stv_c9_p_stall", 32'(p_stall), 32'd1);
        chk("stv_c9_ld_rdata", ld_rdata, 32'hDEAD_BEEF);
        if (p_stall) obs_stall++;
        ld_req = 1'b0;
        #1;
        chk("stv_c9_m_E", 32'(m_E), 32'd0);
        tick();
        chk("stv_c10_ld_ack", 32'(ld_ack), 32'd0);
        if (p_stall) obs_stall++;
        tick();
        chk("stv_c11_p_stall", 32'(p_stall), 32'd0);
        chk("stv_c11_own_p", 32'(m_A), 32'h40);
        chk("stv_c11_m_E", 32'(m_E), 32'd1);
`ifdef DMEM_ARB_STATS_EN
        chk("stat_grants", 32'(ld_grants), 32'd1);
        chk("stat_stall", 32'(stall_cycles), 32'(obs_stall));
`endif

        // Burst limit: P and loader both continuously busy
        ld_req = 1'b1;
        for (int i = 0; i < 21; i++) begin
            #1;
            if (ld_ack) acks++;
            if (acks == 4 && !p_stall && m_E && m_A == 8'h40) p_after++;
            tick();
        end
        chk("burst_acks", 32'(acks), 32'd4);
        chk("burst_p_access", 32'(p_after > 0), 32'd1);

        // Reset landing on a loader access cycle
        p_E = 1'b0;
        tick();
        #1;
        chk("rstl_access_m_E", 32'(m_E), 32'd1);
        chk("rstl_access_m_A", 32'(m_A), 32'h10);
        reset = 1'b1;
        #1;
        chk("rstl_m_E", 32'(m_E), 32'd0);
        chk("rstl_p_stall", 32'(p_stall), 32'd0);
        tick();
        reset = 1'b0;  ld_req = 1'b0;  p_E = 1'b1;
        #1;
        chk("rstl_ld_ack", 32'(ld_ack), 32'd0);
        chk("rstl_ld_rdata", ld_rdata, 32'h0);
        chk("rstl_own_p", 32'(m_A), 32'h40);
        chk("rstl_p_stall_after", 32'(p_stall), 32'd0);
`ifdef DMEM_ARB_STATS_EN
        chk("stat_rst2_stall", 32'(stall_cycles), 32'd0);
        chk("stat_rst2_grants", 32'(ld_grants), 32'd0);
`endif
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single data-memory port between the pipeline MEM stage (port P) and a loader/debug requester (port L). The pipeline owns memory by default. L gets access when P is idle, or when L has waited STARVE_LIMIT cycles. While L owns memory and P wants it, P sees a stall. Sits between the MEM stage and data_memory, and drives the memory's E/RW/Size/A/DI.

Parameters:
ADDR_W, 8, memory address bits forwarded to data memory
STARVE_LIMIT, 8, max cycles a pending L request waits while P keeps memory busy (>=1)
MAX_BURST, 4, max L accesses per ownership while P is waiting (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
p_E  in  1  pipeline memory enable
p_RW  in  1  pipeline read(0)/write(1)
p_Size  in  1  pipeline byte(0)/word(1)
p_AD  in  32  pipeline address from ALU; low ADDR_W bits used
p_IN  in  32  pipeline write data
p_stall  out  1  pipeline must hold MEM stage
p_rdata  out  32  memory read data to MEM-stage mux (combinational DO)
ld_req  in  1  loader request; held stable until ld_ack
ld_RW  in  1  loader read/write
ld_Size  in  1  loader byte/word
ld_addr  in  ADDR_W  loader address
ld_wdata  in  32  loader write data
ld_ack  out  1  one-cycle pulse: access done
ld_rdata  out  32  registered read data, valid with ld_ack
m_E, m_RW, m_Size  out  1  to data memory
m_A  out  ADDR_W  to data memory
m_DI  out  32  to data memory
m_DO  in  32  from data memory

Behaviour:
- States: OWN_P (reset), OWN_L. State, wait_cnt, burst_cnt, ld_ack and ld_rdata are registered. ld_rdata resets to 0; all other outputs are combinational from state and inputs.
- reset=1: state<=OWN_P, counters<=0, ld_ack<=0, ld_rdata<=0. m_E forced 0 during the reset cycle. p_stall=0 during reset. A loader access in flight is dropped, with no ack.
- OWN_P:
  - m_* = p_*; p_stall=0; p_rdata=m_DO.
  - If ld_req=1 and p_E=1: wait_cnt increments, saturating at STARVE_LIMIT.
  - Go to OWN_L next cycle when ld_req=1 and (p_E=0 or wait_cnt==STARVE_LIMIT-1).
  - On that transition, wait_cnt<=0 and burst_cnt<=0.
  - No L access occurs in the transition cycle.
- OWN_L:
  - p_stall = p_E.
  - L access cycle when ld_req=1 and ld_ack=0: m_E=1 and m_* = ld_*. Next edge: ld_ack<=1, ld_rdata<=m_DO (reads only; writes leave ld_rdata unchanged), burst_cnt+1.
  - Ack cycle (ld_ack=1): m_E=0. L may drop or change its request; a new request is sampled next cycle.
  - Return to OWN_P next cycle when either:
    - ld_req=0 and ld_ack=0; or
    - in the ack cycle, p_E=1 and burst_cnt==MAX_BURST.
- Every L access therefore takes 2 cycles (access + ack). The first L access occurs 1 cycle after grant.
- Simultaneous events:
  - p_E rising in OWN_L: the stall is immediate, and the P access happens in the first OWN_P cycle.
  - ld_req with p_E=0 in OWN_P: grant next cycle.
- A P access is never split or duplicated. Any cycle with p_E=1 and p_stall=0 is exactly one memory access.
- Loader latency bound: at most STARVE_LIMIT+2 cycles from ld_req to ld_ack.

Optional Feature:
DMEM_ARB_STATS_EN: adds outputs stall_cycles[15:0] and ld_grants[15:0].
- stall_cycles counts cycles with p_stall=1.
- ld_grants counts OWN_P->OWN_L transitions.
- Both are 16-bit, saturating at 16'hFFFF, and reset to 0.
- Without the macro, neither the ports nor the counters exist, and behaviour is otherwise identical.

Decomposition:
- Shared package holds the state enum (OWN_P, OWN_L) and constants RW_READ=0, RW_WRITE=1, SIZE_BYTE=0, SIZE_WORD=1.
- One sub-module, dmem_arb_counter: parameterised saturating counter with clear, used for wait_cnt, burst_cnt and the stats counters.
- FSM and muxing stay in dmem_arbiter.

Test Plan:
- Idle P, loader word write 0xDEADBEEF @0x10:
  - ld_req at cycle 0 -> OWN_L at cycle 1; memory write at cycle 1 with m_A=0x10; ld_ack at cycle 2.
  - Loader then reads 0x10 -> ld_rdata=0xDEADBEEF with ld_ack.
- P busy every cycle, ld_req held, STARVE_LIMIT=8 -> grant after 8 cycles.
  - p_stall=1 during the L access and ack cycles only.
  - Control returns to OWN_P the cycle after ld_req drops.
- MAX_BURST=4, p_E=1 and ld_req held continuously -> exactly 4 ld_ack pulses, then return to OWN_P.
  - At least one unstalled P access occurs before the next grant.
- Reset asserted during an L access cycle -> no ld_ack, state OWN_P, m_E=0 in the reset cycle, ld_rdata=0.
- Byte write via P: p_E=1, p_RW=1, p_Size=0, p_AD=0x0000_0123, p_IN=0xAB.
  - m_A=0x23, m_Size=0, m_E=1, p_stall=0 in the same cycle.
- With DMEM_ARB_STATS_EN: run the starvation scenario above.
  - ld_grants=1; stall_cycles equals the observed count of p_stall=1 cycles.
  - reset -> both 0.
